// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-write queue between the memory stage and dmem.
// Stores are queued and retired to dmem only in idle cycles (no load, no store),
// or forcibly when a store meets a full queue. Loads forward from the newest
// matching queued store, otherwise they see dmem read data.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   cpu_we, cpu_re   store / load request (both set is treated as a store)
//   cpu_a, cpu_wd    byte address (word part used) and store data
//   cpu_rd           load data, forwarded or from dmem
//   stall            store could not be accepted this cycle (queue full)
//   empty            no pending stores
//   mem_we/a/wd/rd   dmem write enable, address, write data, read data
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        stall,
    output logic        empty,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    logic [29:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_idle;
    logic          w_push;
    logic          w_pop;

    assign w_full = r_count == (AW+1)'(DEPTH);
    assign w_idle = !cpu_we && !cpu_re;
    // Reset cycles neither accept nor retire, so discarded stores never reach dmem.
    assign w_push = !reset && cpu_we && !w_full;
    assign w_pop  = !reset && ((cpu_we && w_full) || (w_idle && r_count != '0));

    assign stall  = !reset && cpu_we && w_full;
    assign empty  = r_count == '0;
    assign mem_we = w_pop;
    assign mem_a  = w_pop ? {r_addr[r_head], 2'b00} : cpu_a;
    assign mem_wd = w_pop ? r_data[r_head] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_push) begin
            r_tail  <= r_tail + 1'b1;
            r_count <= r_count + 1'b1;
        end else if (w_pop) begin
            r_head  <= r_head + 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= cpu_a[31:2];
            r_data[r_tail] <= cpu_wd;
        end
    end

    // Scan oldest to newest so the newest valid match wins; only valid slots take part.
    always_comb begin
        cpu_rd = mem_rd;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < r_count && r_addr[r_head + AW'(i)] == cpu_a[31:2])
                cpu_rd = r_data[r_head + AW'(i)];
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: scoreboard bench for dmem_store_buffer with a behavioural dmem.
// Expected dmem writes and load data are queued when stimulus is issued; a monitor
// on the falling edge pops and compares whenever the DUT writes dmem or serves a load.
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_a;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        stall;
    logic        empty;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] dmem [64];
    logic [63:0] wq [$];
    logic [31:0] lq [$];
    logic        armed = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_a(cpu_a), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall),
        .empty(empty), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
    assign mem_rd = dmem[mem_a[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (mem_we) begin
                if (wq.size() == 0) chk("unexpected_write_addr", mem_a, 32'hFFFF_FFFF);
                else begin
                    logic [63:0] e;
                    e = wq.pop_front();
                    chk("write_addr", mem_a, e[63:32]);
                    chk("write_data", mem_wd, e[31:0]);
                end
            end
            if (cpu_re) begin
                if (lq.size() == 0) chk("unexpected_load", cpu_rd, 32'hFFFF_FFFF);
                else chk("load_data", cpu_rd, lq.pop_front());
            end
        end
    end

    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset = rst; cpu_we = we; cpu_re = re; cpu_a = a; cpu_wd = wd;
        if (we && !rst && !stall) wq.push_back({a & 32'hFFFF_FFFC, wd});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dmem[i] = 32'hD000_0000 | 32'(i);
        reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_a = 32'h0; cpu_wd = 32'h0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        armed = 1'b1;
        idle();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_a", mem_a, 32'h0000_1234);
        chk("rst_mem_wd", mem_wd, 32'h0);
        // 1: single store then drain
        step(1'b0, 1'b1, 1'b0, 32'h20, 32'h1111_1111);
        chk("t1_mem_we", 32'(mem_we), 32'd0);
        idle();
        chk("t1_count", 32'(dut.r_count), 32'd1);
        chk("t1_drain_we", 32'(mem_we), 32'd1);
        chk("t1_drain_a", mem_a, 32'h20);
        idle();
        chk("t1_dmem8", dmem[8], 32'h1111_1111);
        chk("t1_empty", 32'(empty), 32'd1);
        // 2: store then immediate load forwards
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'h0000_AAAA);
        lq.push_back(32'h0000_AAAA);
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
        chk("t2_load_no_drain", 32'(mem_we), 32'd0);
        chk("t2_dmem16_old", dmem[16], 32'hD000_0010);
        idle();
        idle();
        chk("t2_dmem16", dmem[16], 32'h0000_AAAA);
        // 3: duplicate address, newest wins
        step(1'b0, 1'b1, 1'b0, 32'h44, 32'h1);
        step(1'b0, 1'b1, 1'b0, 32'h44, 32'h2);
        lq.push_back(32'h2);
        step(1'b0, 1'b0, 1'b1, 32'h44, 32'h0);
        idle();
        idle();
        idle();
        chk("t3_dmem17", dmem[17], 32'h2);
        chk("t3_empty", 32'(empty), 32'd1);
        // 4: five back-to-back stores with DEPTH=4
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'(i * 4), 32'h100 + 32'(i));
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'h104);
        chk("t4_stall", 32'(stall), 32'd1);
        chk("t4_force_we", 32'(mem_we), 32'd1);
        chk("t4_force_a", mem_a, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'h104);
        chk("t4_accept_stall", 32'(stall), 32'd0);
        idle();
        chk("t4_count", 32'(dut.r_count), 32'd4);
        for (int i = 0; i < 4; i++) idle();
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_dmem4", dmem[4], 32'h104);
        // 5: reset discards pending stores
        step(1'b0, 1'b1, 1'b0, 32'h60, 32'h600);
        step(1'b0, 1'b1, 1'b0, 32'h64, 32'h640);
        step(1'b0, 1'b1, 1'b0, 32'h68, 32'h680);
        void'(wq.pop_back()); void'(wq.pop_back()); void'(wq.pop_back());
        step(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
        chk("t5_rst_we", 32'(mem_we), 32'd0);
        idle();
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        idle();
        chk("t5_dmem24", dmem[24], 32'hD000_0018);
        chk("t5_dmem26", dmem[26], 32'hD000_001A);
        // 6: load miss with a non-matching queued entry
        step(1'b0, 1'b1, 1'b0, 32'h30, 32'h300);
        lq.push_back(32'hD000_001F);
        step(1'b0, 1'b0, 1'b1, 32'h7C, 32'h0);
        chk("t6_mem_a", mem_a, 32'h7C);
        chk("t6_mem_we", 32'(mem_we), 32'd0);
        idle();
        idle();
        chk("t6_dmem12", dmem[12], 32'h300);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("lq_drained", 32'(lq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
